// File: rtl/reconocedor_patrones_param.sv
// Serial pattern recogniser with runtime-loaded pattern, don't-care mask,
// overlap mode, one-cycle match pulse and saturating match counter.
module reconocedor_patrones_param #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [PAT_LEN-1:0] mask,
  input  logic               overlap,
  input  logic               clr,
  output logic               out,
  output logic               armed,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  typedef enum logic {
    IDLE,
    SEARCH
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] mask_q, mask_d;
  logic               ovl_q, ovl_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;

  logic               acc;
  logic               hit;
  logic [PAT_LEN-1:0] nh;
  logic [FW-1:0]      nf;

  assign acc = (state_q == SEARCH) && in_valid && !load && !clr;
  assign nh  = {hist_q[PAT_LEN-2:0], in};
  assign nf  = (fill_q == FULL) ? FULL : fill_q + FW'(1);
  assign hit = acc && (nf == FULL) && (((nh ^ pat_q) & mask_q) == '0);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;

    unique case (state_q)
      IDLE:    if (load) state_d = SEARCH;
      SEARCH:  state_d = SEARCH;
      default: state_d = IDLE;
    endcase

    if (acc) begin
      hist_d = nh;
      fill_d = nf;
      if (hit) begin
        out_d = 1'b1;
        if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
        // non-overlap: the matched window must be refilled from scratch
        if (!ovl_q) fill_d = '0;
      end
    end

    if (load) begin
      pat_d  = pattern;
      mask_d = mask;
      ovl_d  = overlap;
      hist_d = '0;
      fill_d = '0;
    end

    if (clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      mask_q  <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out         = out_q;
  assign armed       = (state_q == SEARCH);
  assign match_count = cnt_q;
  assign count_sat   = &cnt_q;

endmodule
